fetch_seq_ctrl: RTL and testbench
=================================

Name: fetch_seq_ctrl

Overview:
Sequencer for the instruction-fetch stage. It owns the fetch-stage control strobes: no_new_fetch, FREEZE, taken_branch1, nextInstruction_address and fetchNull2. It arbitrates redirect sources (exception, decode branch), handles instruction-memory wait states and decode stalls, and squashes the wrong-path slot after a redirect. It sits between the decode/exception logic and the fetch stage, and faces the instruction-memory ready handshake.

Parameters:
ADDR_W, 32, address width of targets and vectors
BOOT_CYCLES, 2, cycles held frozen after reset release before first fetch
MEM_TIMEOUT, 15, max consecutive not-ready cycles tolerated in MEMWAIT

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous active-low reset
id_stall  input  1  decode hazard; hold IF/ID contents
br_taken  input  1  decode resolved taken branch (single-cycle pulse)
br_target  input  ADDR_W  branch target, valid with br_taken
exc_req  input  1  exception redirect request (single-cycle pulse)
exc_vector  input  ADDR_W  exception handler address, valid with exc_req
im_ready  input  1  instruction memory has data for current fetch address
halt_req  input  1  stop fetching after current slot
resume  input  1  leave HALT (ignored if timeout flag set)
no_new_fetch  output  1  hold IF pipeline register
FREEZE  output  1  global fetch freeze
taken_branch1  output  1  select nextInstruction_address as fetch address
nextInstruction_address  output  ADDR_W  redirect address
fetchNull2  output  1  null the instruction entering IF/ID
fetch_timeout  output  1  sticky: MEM_TIMEOUT exceeded
stall_cnt  output  32  perf: stall cycles (feature-gated)
redirect_cnt  output  32  perf: redirects taken (feature-gated)

Behaviour:
- Interface decision: one clock (CLK); reset (RESET) asynchronous, active-low.
- Reset values: state=BOOT, FREEZE=1, no_new_fetch=1, taken_branch1=0, nextInstruction_address=0, fetchNull2=0, fetch_timeout=0, counters=0, pending redirect cleared.
- All outputs are registered: one-cycle latency from inputs.
- States:
  - BOOT: counts BOOT_CYCLES after reset release, then moves to RUN.
  - RUN:
    - !im_ready -> MEMWAIT.
    - id_stall -> STALL.
    - halt_req -> HALT.
  - STALL: no_new_fetch=1. Returns to RUN when id_stall=0.
  - MEMWAIT: no_new_fetch=1, wait counter increments.
    - im_ready -> RUN.
    - Counter reaching MEM_TIMEOUT -> set fetch_timeout, go to HALT.
  - HALT: FREEZE=1, no_new_fetch=1. resume with fetch_timeout=0 -> RUN.
- Redirect priority: exc_req over br_taken over everything else.
  - In RUN or STALL: the next cycle drives taken_branch1=1 and nextInstruction_address=target for exactly one cycle.
  - fetchNull2=1 on the same cycle, squashing the wrong-path slot.
  - A redirect overrides STALL for that cycle: no_new_fetch=0.
- Redirect in MEMWAIT: target latched into a one-entry pending register.
  - A later exc_req overwrites a pending branch; a later branch does not overwrite a pending exception.
  - Issued on the first cycle after im_ready=1.
- Redirect in BOOT or HALT: only exc_req is latched; it is issued on exit. br_taken is dropped.
- exc_req and br_taken in the same cycle: only exc_vector is used; br_taken is dropped.
- halt_req coincident with a redirect: the redirect is issued first, then HALT.
- Wait counter is 4+ bits wide, cleared on leaving MEMWAIT, and saturates (no wrap).
- RESET asserted mid-operation: immediate return to reset values, including the pending register and the sticky flag.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: stall_cnt increments in every cycle where no_new_fetch=1 in STALL or MEMWAIT; redirect_cnt increments per issued redirect. Both wrap at 2^32.
- Undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - state enum {BOOT, RUN, STALL, MEMWAIT, HALT}
  - redirect-source enum {NONE, BRANCH, EXC}
  - localparam widths
- One sub-module: fetch_redirect_latch (pending target register plus priority merge).

Test Plan:
- RESET low then high, BOOT_CYCLES=2 -> FREEZE=1 for 2 cycles after release, then FREEZE=0 and no_new_fetch=0.
- RUN, br_taken with br_target=0x0000_0040 -> next cycle taken_branch1=1, nextInstruction_address=0x40, fetchNull2=1 for one cycle only.
- im_ready=0 for 3 cycles, br_taken(0x80) in cycle 2 -> no_new_fetch=1 for 3 cycles, redirect to 0x80 on the cycle after im_ready=1.
- exc_req(0x180) and br_taken(0x40) in the same cycle -> nextInstruction_address=0x180, branch never issued.
- im_ready=0 for 16 cycles with MEM_TIMEOUT=15 -> fetch_timeout=1, state HALT, resume ignored until RESET.
- With FETCH_PERF_CNT_EN: 4 stall cycles plus 2 redirects -> stall_cnt=4, redirect_cnt=2. Without it: both read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch-stage sequencer: FSM states and redirect sources.
// Used by fetch_seq_ctrl and fetch_redirect_latch.
package fetch_ctrl_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [2:0] {
      BOOT,
      RUN,
      STALL,
      MEMWAIT,
      HALT
   } fetch_state_e;

   typedef enum logic [1:0] {
      NONE,
      BRANCH,
      EXC
   } redirect_src_e;

endpackage

// File: rtl/fetch_redirect_latch.sv
// One-entry pending redirect register plus the exception-over-branch priority
// merge of the live request with whatever is already pending.
module fetch_redirect_latch
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              exc_req,
   input  logic [ADDR_W-1:0] exc_vector,
   input  logic              br_accept,
   input  logic              issue,
   output redirect_src_e     merged_src,
   output logic [ADDR_W-1:0] merged_addr
);

   redirect_src_e     pend_src;
   logic [ADDR_W-1:0] pend_addr;

   // A new branch replaces a pending branch but never a pending exception.
   always_comb begin
      merged_src  = pend_src;
      merged_addr = pend_addr;
      if (exc_req) begin
         merged_src  = EXC;
         merged_addr = exc_vector;
      end else if (br_taken && br_accept && (pend_src != EXC)) begin
         merged_src  = BRANCH;
         merged_addr = br_target;
      end
   end

   // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pend_src  <= NONE;
         pend_addr <= '0;
      end else begin
         pend_src  <= issue ? NONE : merged_src;
         pend_addr <= merged_addr;
      end
   end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: boot hold, memory wait/timeout, decode stall, halt and redirects.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_seq_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BOOT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              id_stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              exc_req,
   input  logic [ADDR_W-1:0] exc_vector,
   input  logic              im_ready,
   input  logic              halt_req,
   input  logic              resume,
   output logic              no_new_fetch,
   output logic              FREEZE,
   output logic              taken_branch1,
   output logic [ADDR_W-1:0] nextInstruction_address,
   output logic              fetchNull2,
   output logic              fetch_timeout,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  redirect_cnt
);

   localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
   localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

   fetch_state_e      state, next_state;
   logic [BOOT_W-1:0] boot_cnt, boot_cnt_d;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
   logic              timeout_d, nnf_d, freeze_d, issue, br_accept, redirect_valid;
   logic [ADDR_W-1:0] addr_d, merged_addr;
   redirect_src_e     merged_src;

   // Branches are only meaningful while the pipeline is live; BOOT/HALT keep exceptions only.
   assign br_accept      = (state == RUN) || (state == STALL) || (state == MEMWAIT);
   assign redirect_valid = (merged_src != NONE);

   fetch_redirect_latch #(.ADDR_W(ADDR_W)) u_redirect (
      .CLK         (CLK),
      .RESET       (RESET),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .exc_req     (exc_req),
      .exc_vector  (exc_vector),
      .br_accept   (br_accept),
      .issue       (issue),
      .merged_src  (merged_src),
      .merged_addr (merged_addr)
   );

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      next_state = state;
      boot_cnt_d = boot_cnt;
      wait_cnt_d = '0;
      timeout_d  = fetch_timeout;
      issue      = 1'b0;
      unique case (state)
         BOOT: begin
            if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
               next_state = RUN;
               issue      = redirect_valid;
            end else begin
               boot_cnt_d = boot_cnt + BOOT_W'(1);
            end
         end
         RUN, STALL: begin
            if (redirect_valid) begin
               issue = 1'b1;
               if (halt_req)      next_state = HALT;
               else if (id_stall) next_state = STALL;
               else               next_state = RUN;
            end else if (state == STALL) begin
               if (!id_stall) next_state = RUN;
            end else if (!im_ready) begin
               next_state = MEMWAIT;
               wait_cnt_d = WAIT_W'(1);
            end else if (id_stall) begin
               next_state = STALL;
            end else if (halt_req) begin
               next_state = HALT;
            end
         end
         MEMWAIT: begin
            if (im_ready) begin
               next_state = RUN;
               issue      = redirect_valid;
            end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
               timeout_d  = 1'b1;
               next_state = HALT;
            end else begin
               wait_cnt_d = wait_cnt + WAIT_W'(1);
            end
         end
         HALT: begin
            if (resume && !fetch_timeout) begin
               next_state = RUN;
               issue      = redirect_valid;
            end
         end
         default: next_state = BOOT;
      endcase

      // A redirect cycle always lets the new fetch through, even on the way into HALT.
      nnf_d    = (next_state != RUN) && !issue;
      freeze_d = ((next_state == BOOT) || (next_state == HALT)) && !issue;
      addr_d   = issue ? merged_addr : nextInstruction_address;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state                   <= BOOT;
         boot_cnt                <= '0;
         wait_cnt                <= '0;
         FREEZE                  <= 1'b1;
         no_new_fetch            <= 1'b1;
         taken_branch1           <= 1'b0;
         nextInstruction_address <= '0;
         fetchNull2              <= 1'b0;
         fetch_timeout           <= 1'b0;
      end else begin
         state                   <= next_state;
         boot_cnt                <= boot_cnt_d;
         wait_cnt                <= wait_cnt_d;
         FREEZE                  <= freeze_d;
         no_new_fetch            <= nnf_d;
         taken_branch1           <= issue;
         nextInstruction_address <= addr_d;
         fetchNull2              <= issue;
         fetch_timeout           <= timeout_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (no_new_fetch && ((state == STALL) || (state == MEMWAIT)))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (issue)
            redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt    = '0;
   assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: vector table for single-cycle behaviour,
// hand sequences for timeout, mid-operation reset and perf counters.
module tb_fetch_seq_ctrl;

   logic        CLK, RESET;
   logic        id_stall, br_taken, exc_req, im_ready, halt_req, resume;
   logic [31:0] br_target, exc_vector;
   logic        no_new_fetch, FREEZE, taken_branch1, fetchNull2, fetch_timeout;
   logic [31:0] nextInstruction_address, stall_cnt, redirect_cnt;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef FETCH_PERF_CNT_EN
   localparam logic [31:0] EXP_STALL = 32'd4;
   localparam logic [31:0] EXP_REDIR = 32'd2;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
   localparam logic [31:0] EXP_REDIR = 32'd0;
`endif

   fetch_seq_ctrl #(.ADDR_W(32), .BOOT_CYCLES(2), .MEM_TIMEOUT(15)) dut (
      .CLK                     (CLK),
      .RESET                   (RESET),
      .id_stall                (id_stall),
      .br_taken                (br_taken),
      .br_target               (br_target),
      .exc_req                 (exc_req),
      .exc_vector              (exc_vector),
      .im_ready                (im_ready),
      .halt_req                (halt_req),
      .resume                  (resume),
      .no_new_fetch            (no_new_fetch),
      .FREEZE                  (FREEZE),
      .taken_branch1           (taken_branch1),
      .nextInstruction_address (nextInstruction_address),
      .fetchNull2              (fetchNull2),
      .fetch_timeout           (fetch_timeout),
      .stall_cnt               (stall_cnt),
      .redirect_cnt            (redirect_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        stl, br, exc, rdy, hlt, res;
      logic [31:0] tgt, vec;
      logic        nnf, frz, tb1, fnl;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic stl, br, exc, rdy, hlt, res,
                               input logic [31:0] tgt, vec,
                               input logic nnf, frz, tb1, fnl,
                               input logic [31:0] addr);
      vec_t v;
      v.stl = stl; v.br = br; v.exc = exc; v.rdy = rdy; v.hlt = hlt; v.res = res;
      v.tgt = tgt; v.vec = vec;
      v.nnf = nnf; v.frz = frz; v.tb1 = tb1; v.fnl = fnl; v.addr = addr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then land 1 ns after the sampling edge.
   task automatic step(input logic stl, br, exc, rdy, hlt, res, input logic [31:0] tgt, vec);
      id_stall = stl; br_taken = br; exc_req = exc; im_ready = rdy;
      halt_req = hlt; resume = res; br_target = tgt; exc_vector = vec;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/FREEZE"}, FREEZE, 1);
      check({tag, "/nnf"}, no_new_fetch, 1);
      check({tag, "/tb1"}, taken_branch1, 0);
      check({tag, "/addr"}, nextInstruction_address, 0);
      check({tag, "/null"}, fetchNull2, 0);
      check({tag, "/timeout"}, fetch_timeout, 0);
      check({tag, "/stall_cnt"}, stall_cnt, 0);
      check({tag, "/redirect_cnt"}, redirect_cnt, 0);
   endtask

   task automatic pulse_reset(input string tag);
      #2 RESET = 1'b0;
      #1 check_reset_values(tag);
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   initial begin
      // stl br exc rdy hlt res  tgt  vec   | nnf frz tb1 null addr
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   1,1,0,0, 32'h0));   // boot cycle 1
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h0));   // boot exit
      tbl.push_back(mk(0,1,0,1,0,0, 32'h40,  32'h0,   0,0,1,1, 32'h40));  // branch in RUN
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h40));  // one cycle only
      tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h40));  // memwait 1
      tbl.push_back(mk(0,1,0,0,0,0, 32'h80,  32'h0,   1,0,0,0, 32'h40));  // memwait 2 + branch
      tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h40));  // memwait 3
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,1,1, 32'h80));  // pending issued
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h80));
      tbl.push_back(mk(0,1,1,1,0,0, 32'h40,  32'h180, 0,0,1,1, 32'h180)); // exc beats branch
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h180)); // branch never issued
      tbl.push_back(mk(1,0,0,1,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h180)); // stall
      tbl.push_back(mk(1,0,0,1,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h180));
      tbl.push_back(mk(1,1,0,1,0,0, 32'h200, 32'h0,   0,0,1,1, 32'h200)); // redirect overrides stall
      tbl.push_back(mk(1,0,0,1,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h200));
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h200)); // stall released
      tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h200));
      tbl.push_back(mk(0,0,1,0,0,0, 32'h0,   32'h300, 1,0,0,0, 32'h200)); // exc pending
      tbl.push_back(mk(0,1,0,0,0,0, 32'h400, 32'h0,   1,0,0,0, 32'h200)); // branch must not overwrite
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,1,1, 32'h300));
      tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h300));
      tbl.push_back(mk(0,1,0,0,0,0, 32'h500, 32'h0,   1,0,0,0, 32'h300)); // branch pending
      tbl.push_back(mk(0,0,1,0,0,0, 32'h0,   32'h600, 1,0,0,0, 32'h300)); // exc overwrites it
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,1,1, 32'h600));
      tbl.push_back(mk(0,1,0,1,1,0, 32'h700, 32'h0,   0,0,1,1, 32'h700)); // redirect before halt
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   1,1,0,0, 32'h700)); // now halted
      tbl.push_back(mk(0,1,0,1,0,0, 32'h800, 32'h0,   1,1,0,0, 32'h700)); // branch dropped in HALT
      tbl.push_back(mk(0,0,1,1,0,0, 32'h0,   32'h900, 1,1,0,0, 32'h700)); // exc latched in HALT
      tbl.push_back(mk(0,0,0,1,0,1, 32'h0,   32'h0,   0,0,1,1, 32'h900)); // issued on resume
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h900));
      tbl.push_back(mk(0,0,0,1,1,0, 32'h0,   32'h0,   1,1,0,0, 32'h900)); // plain halt
      tbl.push_back(mk(0,0,0,1,0,1, 32'h0,   32'h0,   0,0,0,0, 32'h900)); // resume, nothing pending

      RESET = 1'b1;
      id_stall = 0; br_taken = 0; exc_req = 0; im_ready = 1;
      halt_req = 0; resume = 0; br_target = '0; exc_vector = '0;
      #1 RESET = 1'b0;
      #1 check_reset_values("reset");
      @(negedge CLK);
      RESET = 1'b1;
      #1 check("boot_hold0/FREEZE", FREEZE, 1);

      foreach (tbl[i]) begin
         step(tbl[i].stl, tbl[i].br, tbl[i].exc, tbl[i].rdy, tbl[i].hlt, tbl[i].res,
              tbl[i].tgt, tbl[i].vec);
         check($sformatf("v%0d/nnf", i), no_new_fetch, tbl[i].nnf);
         check($sformatf("v%0d/FREEZE", i), FREEZE, tbl[i].frz);
         check($sformatf("v%0d/tb1", i), taken_branch1, tbl[i].tb1);
         check($sformatf("v%0d/null", i), fetchNull2, tbl[i].fnl);
         check($sformatf("v%0d/addr", i), nextInstruction_address, tbl[i].addr);
         check($sformatf("v%0d/timeout", i), fetch_timeout, 0);
      end

      // Timeout boundary: 15 not-ready cycles are tolerated, the 16th trips the flag.
      pulse_reset("reset2");
      idle();
      idle();
      check("to/boot_done", FREEZE, 0);
      repeat (15) step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("to15/timeout", fetch_timeout, 0);
      check("to15/nnf", no_new_fetch, 1);
      idle();
      check("to15_recover/nnf", no_new_fetch, 0);
      check("to15_recover/timeout", fetch_timeout, 0);
      repeat (15) step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("to16_pre/timeout", fetch_timeout, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      check("to16/timeout", fetch_timeout, 1);
      check("to16/FREEZE", FREEZE, 1);
      step(0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
      check("resume_ignored/FREEZE", FREEZE, 1);
      check("resume_ignored/timeout", fetch_timeout, 1);
      step(0, 0, 1, 1, 0, 0, 32'h0, 32'hA00);
      check("halt_exc/FREEZE", FREEZE, 1);

      // Asynchronous reset mid-cycle must also drop the pending exception.
      pulse_reset("midreset");
      idle();
      idle();
      check("post_reset/FREEZE", FREEZE, 0);
      check("post_reset/tb1", taken_branch1, 0);
      check("post_reset/addr", nextInstruction_address, 0);

      // Perf counters: 4 stall cycles and 2 redirects.
      pulse_reset("reset3");
      idle();
      idle();
      repeat (4) step(1, 0, 0, 1, 0, 0, 32'h0, 32'h0);
      idle();
      step(0, 1, 0, 1, 0, 0, 32'h40, 32'h0);
      step(0, 1, 0, 1, 0, 0, 32'h80, 32'h0);
      idle();
      check("perf/stall_cnt", stall_cnt, EXP_STALL);
      check("perf/redirect_cnt", redirect_cnt, EXP_REDIR);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
